rb_ctrl: RTL and testbench
==========================

Name: rb_ctrl

Overview:
- Write/read sequencer for the row-buffer BRAM bank used in neighbourhood image processing.
- Accepts a 32-bit pixel-word stream and writes each image row into one BRAM, rotating round-robin through the BRAMs.
- Once KERNEL-1 rows are buffered, it issues a same-column read of all BRAMs with every incoming word. It emits window-valid metadata aligned to the one-cycle BRAM read latency.

Parameters:
- BRAMS, 4, number of row-buffer BRAMs; must be >= KERNEL.
- BRAM_ADDR, 2, width of the BRAM select field; must be >= clog2(BRAMS).
- DEPTH_ADDR, 8, width of the per-BRAM word address.
- ROW_WORDS, 256, 32-bit words per image row; must be <= 2**DEPTH_ADDR.
- ROWS, 256, rows per frame.
- KERNEL, 3, neighbourhood height in rows; must be >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  controller accepts word
- in_sof  in  1  first word of frame (qualified by in_valid)
- in_data  in  32  pixel word
- wr_en  out  1  BRAM port-A write strobe
- wr_sel  out  BRAM_ADDR  target BRAM
- wr_addr  out  DEPTH_ADDR  column address
- wr_data  out  32  write data
- rd_en  out  1  BRAM port-B enable (all BRAMs)
- rd_addr  out  DEPTH_ADDR  read column address
- out_valid  out  1  window column ready (BRAM dout valid this cycle)
- out_col  out  DEPTH_ADDR  column of window
- out_row  out  clog2(ROWS)  row index of newest (incoming) row
- out_base_sel  out  BRAM_ADDR  BRAM holding oldest row of window
- out_cur_data  out  32  incoming word, delayed 1 cycle
- out_eol  out  1  with out_valid: last column
- out_eof  out  1  with out_valid: last column of last row
- sof_err  out  1  one-cycle pulse: in_sof seen mid-frame

Behaviour:
- Reset: all outputs 0, except in_ready = 1. FSM = IDLE, counters col/row/sel = 0.
- Beat accepted = in_valid & in_ready. in_ready = 1 in IDLE/FILL/STREAM and 0 in DONE.
- FSM states: IDLE, FILL, STREAM, DONE.
- IDLE:
  - Beats without in_sof are accepted and discarded; no wr_en.
  - A beat with in_sof is written as row 0, col 0, sel 0 in the same cycle (combinational wr_*). Next state = FILL, or STREAM if KERNEL-1 == 0 (not permitted).
- Writes, any state except IDLE-discard:
  - wr_en = accepted beat; wr_sel = sel; wr_addr = col; wr_data = in_data.
  - col increments per beat. At col == ROW_WORDS-1: col -> 0, row++, sel -> (sel == BRAMS-1) ? 0 : sel+1. Explicit wrap; BRAMS need not be a power of 2.
- FILL -> STREAM when the row counter reaches KERNEL-1 (i.e. after the last word of row KERNEL-2 is written).
- STREAM:
  - Each accepted beat also drives rd_en = 1, rd_addr = col in the same cycle as its write.
  - The write targets sel, which never equals any of the KERNEL-1 previous rows' BRAMs because BRAMS >= KERNEL. There is therefore no read/write collision.
- Output stage (registered, 1 cycle after the STREAM beat):
  - out_valid = 1.
  - out_col, out_row, out_cur_data are the registered beat values.
  - out_base_sel = (sel - (KERNEL-1)) mod BRAMS, computed at beat time.
  - out_eol = (col == ROW_WORDS-1).
  - out_eof = out_eol & (row == ROWS-1).
  - All outputs are 0 when there is no beat.
- End of frame: after the STREAM beat with row == ROWS-1 and col == ROW_WORDS-1 -> DONE.
- DONE: one cycle with in_ready = 0, then IDLE with counters cleared.
- in_sof on an accepted beat in FILL/STREAM:
  - sof_err pulses the next cycle.
  - Counters are reset and the beat is written as row 0/col 0/sel 0. State -> FILL.
  - No out_valid is generated for that beat.
- rst_n asserted mid-frame: immediate return to the reset state. The partial frame is abandoned and out_valid/wr_en/rd_en drop asynchronously.
- Row counter width: clog2(ROWS). Saturation is not needed because DONE ends the frame.

Decomposition:
- Package rb_pkg holds:
  - state enum {IDLE, FILL, STREAM, DONE};
  - DATA_W = 32;
  - a clog2 function;
  - derived ROW_W constant;
  - the modular-subtract helper for base select.
- Sub-module rb_addr_gen: col/row/sel counters with wrap, clear and advance inputs, plus eol/eof flags. The FSM and output register stay in rb_ctrl.

Test Plan:
All scenarios use BRAMS=4, ROW_WORDS=4, ROWS=4, KERNEL=3, DEPTH_ADDR=2, unless stated otherwise.
1. Reset, then 3 beats with in_sof=0 in IDLE -> in_ready=1, wr_en never asserted, out_valid=0.
2. Full frame of 16 beats, data = index 0..15, continuous valid:
   - wr_sel sequence is 0×4, 1×4, 2×4, 3×4.
   - No rd_en for beats 0-7.
   - out_valid on cycles after beats 8-15, with out_base_sel=0 for row 2 and 1 for row 3.
   - out_eof on beat 15's output; in_ready=0 for one cycle, then IDLE.
3. Second frame immediately after the first:
   - sel restarts at 0;
   - no read collision, i.e. wr_sel ∉ {out_base_sel, out_base_sel+1} for every STREAM beat.
4. in_valid toggled 1/0 every cycle during STREAM -> out_valid follows with 1-cycle lag; column/row progression is identical to scenario 2.
5. in_sof reasserted at beat 10 -> sof_err pulses once; that beat is written at sel 0/addr 0; the next 7 beats produce no out_valid.
6. rst_n pulsed low at beat 9 -> all outputs 0 asynchronously; a new sof frame then completes as in scenario 2.

Source files
------------

// File: rtl/rb_pkg.sv
// Shared types and helpers for the row-buffer write/read sequencer.
// Holds the FSM encoding, data width and the small arithmetic helpers.
package rb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int DATA_W = 32;

    // Minimum width is 1 so that single-entry counters still get a real bit.
    function automatic int clog2(input int value);
        int w;
        for (w = 1; (1 << w) < value; w++) begin
        end
        return w;
    endfunction

    localparam int ROWS_DEF = 256;
    localparam int ROW_W    = clog2(ROWS_DEF);

    // (a - b) mod m for 0 <= a < m and 0 <= b <= m; avoids a divider.
    function automatic int mod_sub(input int a, input int b, input int m);
        int r;
        r = a - b;
        if (r < 0) begin
            r = r + m;
        end
        return r;
    endfunction

endpackage

// File: rtl/rb_addr_gen.sv
// Column/row/BRAM-select counters for the row buffer, with explicit wrap.
// clr_i restarts at the origin; clr_i together with adv_i consumes the origin slot.
module rb_addr_gen
    import rb_pkg::*;
#(
    parameter int BRAMS      = 4,
    parameter int BRAM_ADDR  = 2,
    parameter int DEPTH_ADDR = 8,
    parameter int ROW_WORDS  = 256,
    parameter int ROWS       = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     adv_i,
    output logic [DEPTH_ADDR-1:0]    col_o,
    output logic [clog2(ROWS)-1:0]   row_o,
    output logic [BRAM_ADDR-1:0]     sel_o,
    output logic                     eol_o,
    output logic                     eof_o
);

    localparam int RW = clog2(ROWS);
    localparam logic [DEPTH_ADDR-1:0] COL_LAST = DEPTH_ADDR'(ROW_WORDS - 1);
    localparam logic [RW-1:0]         ROW_LAST = RW'(ROWS - 1);
    localparam logic [BRAM_ADDR-1:0]  SEL_LAST = BRAM_ADDR'(BRAMS - 1);

    logic [DEPTH_ADDR-1:0] col_q, col_d, col_b;
    logic [RW-1:0]         row_q, row_d, row_b;
    logic [BRAM_ADDR-1:0]  sel_q, sel_d, sel_b;

    always_comb begin
        col_b = clr_i ? '0 : col_q;
        row_b = clr_i ? '0 : row_q;
        sel_b = clr_i ? '0 : sel_q;
        col_d = col_b;
        row_d = row_b;
        sel_d = sel_b;
        if (adv_i) begin
            if (col_b == COL_LAST) begin
                col_d = '0;
                row_d = row_b + 1'b1;
                // BRAMS need not be a power of two, so wrap explicitly.
                sel_d = (sel_b == SEL_LAST) ? '0 : sel_b + 1'b1;
            end else begin
                col_d = col_b + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            sel_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            sel_q <= sel_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;
    assign sel_o = sel_q;
    assign eol_o = (col_q == COL_LAST);
    assign eof_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/rb_ctrl.sv
// Row-buffer BRAM write/read sequencer: writes rows round-robin into BRAMs and,
// once KERNEL-1 rows are held, reads the same column of all BRAMs per new word.
module rb_ctrl
    import rb_pkg::*;
#(
    parameter int BRAMS      = 4,
    parameter int BRAM_ADDR  = 2,
    parameter int DEPTH_ADDR = 8,
    parameter int ROW_WORDS  = 256,
    parameter int ROWS       = 256,
    parameter int KERNEL     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    wr_en,
    output logic [BRAM_ADDR-1:0]    wr_sel,
    output logic [DEPTH_ADDR-1:0]   wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    rd_en,
    output logic [DEPTH_ADDR-1:0]   rd_addr,
    output logic                    out_valid,
    output logic [DEPTH_ADDR-1:0]   out_col,
    output logic [clog2(ROWS)-1:0]  out_row,
    output logic [BRAM_ADDR-1:0]    out_base_sel,
    output logic [DATA_W-1:0]       out_cur_data,
    output logic                    out_eol,
    output logic                    out_eof,
    output logic                    sof_err
);

    localparam int RW = clog2(ROWS);
    localparam logic [RW-1:0] LAST_FILL_ROW = RW'(KERNEL - 2);

    state_e                state_q;
    logic                  in_ready_q;

    logic [DEPTH_ADDR-1:0] col;
    logic [RW-1:0]         row;
    logic [BRAM_ADDR-1:0]  sel;
    logic                  eol;
    logic                  eof;
    logic [BRAM_ADDR-1:0]  base_sel;

    logic accept;
    logic sof_beat;
    logic wr_beat;
    logic rd_beat;
    logic cnt_clr;

    logic                  out_valid_q;
    logic [DEPTH_ADDR-1:0] out_col_q;
    logic [RW-1:0]         out_row_q;
    logic [BRAM_ADDR-1:0]  out_base_sel_q;
    logic [DATA_W-1:0]     out_cur_data_q;
    logic                  out_eol_q;
    logic                  out_eof_q;
    logic                  sof_err_q;

    // in_ready is low only in DONE, so a DONE-state beat is never accepted.
    assign accept   = in_valid && in_ready_q;
    assign sof_beat = accept && in_sof;
    assign wr_beat  = accept && ((state_q != IDLE) || in_sof);
    assign rd_beat  = accept && (state_q == STREAM) && !in_sof;
    assign cnt_clr  = sof_beat || (state_q == DONE);

    assign base_sel = BRAM_ADDR'(mod_sub(int'(sel), KERNEL - 1, BRAMS));

    rb_addr_gen #(
        .BRAMS      (BRAMS),
        .BRAM_ADDR  (BRAM_ADDR),
        .DEPTH_ADDR (DEPTH_ADDR),
        .ROW_WORDS  (ROW_WORDS),
        .ROWS       (ROWS)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .adv_i  (wr_beat),
        .col_o  (col),
        .row_o  (row),
        .sel_o  (sel),
        .eol_o  (eol),
        .eof_o  (eof)
    );

    // Strobes are gated by rst_n so they drop the instant reset asserts.
    assign wr_en   = wr_beat && rst_n;
    assign wr_sel  = sof_beat ? '0 : sel;
    assign wr_addr = sof_beat ? '0 : col;
    assign wr_data = in_data;
    assign rd_en   = rd_beat && rst_n;
    assign rd_addr = col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_col_q      <= '0;
            out_row_q      <= '0;
            out_base_sel_q <= '0;
            out_cur_data_q <= '0;
            out_eol_q      <= 1'b0;
            out_eof_q      <= 1'b0;
            sof_err_q      <= 1'b0;
        end else begin
            sof_err_q      <= sof_beat && (state_q != IDLE);
            out_valid_q    <= rd_beat;
            out_col_q      <= rd_beat ? col      : '0;
            out_row_q      <= rd_beat ? row      : '0;
            out_base_sel_q <= rd_beat ? base_sel : '0;
            out_cur_data_q <= rd_beat ? in_data  : '0;
            out_eol_q      <= rd_beat && eol;
            out_eof_q      <= rd_beat && eof;
            unique case (state_q)
                IDLE: begin
                    if (sof_beat) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (!sof_beat && wr_beat && eol && (row == LAST_FILL_ROW)) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (sof_beat) begin
                        state_q <= FILL;
                    end else if (rd_beat && eof) begin
                        state_q    <= DONE;
                        in_ready_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_col      = out_col_q;
    assign out_row      = out_row_q;
    assign out_base_sel = out_base_sel_q;
    assign out_cur_data = out_cur_data_q;
    assign out_eol      = out_eol_q;
    assign out_eof      = out_eof_q;
    assign sof_err      = sof_err_q;

endmodule

// File: tb/tb_rb_ctrl.sv
// Bench for rb_ctrl: directed frames plus random traffic against a frame-position model.
module tb_rb_ctrl;

    localparam int BR    = 4;
    localparam int BA    = 2;
    localparam int DA    = 2;
    localparam int RWD   = 4;
    localparam int RS    = 4;
    localparam int K     = 3;
    localparam int TOTAL = RWD * RS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [31:0] in_data;
    logic        wr_en;
    logic [BA-1:0] wr_sel;
    logic [DA-1:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [DA-1:0] rd_addr;
    logic        out_valid;
    logic [DA-1:0] out_col;
    logic [1:0]  out_row;
    logic [BA-1:0] out_base_sel;
    logic [31:0] out_cur_data;
    logic        out_eol;
    logic        out_eof;
    logic        sof_err;

    int checks   = 0;
    int failures = 0;

    // Model: a frame is just a linear word position; row/col/BRAM follow by arithmetic.
    bit m_active = 1'b0;
    int m_pos    = 0;
    bit m_done   = 1'b0;

    rb_ctrl #(
        .BRAMS(BR), .BRAM_ADDR(BA), .DEPTH_ADDR(DA),
        .ROW_WORDS(RWD), .ROWS(RS), .KERNEL(K)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_col(out_col), .out_row(out_row),
        .out_base_sel(out_base_sel), .out_cur_data(out_cur_data),
        .out_eol(out_eol), .out_eof(out_eof), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_done   = 1'b0;
    endtask

    task automatic check_quiet_outputs(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready), 32'd1);
        chk({tag, ".wr_en"},     32'(wr_en), 32'd0);
        chk({tag, ".rd_en"},     32'(rd_en), 32'd0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".out_col"},   32'(out_col), 32'd0);
        chk({tag, ".out_row"},   32'(out_row), 32'd0);
        chk({tag, ".out_base"},  32'(out_base_sel), 32'd0);
        chk({tag, ".out_data"},  out_cur_data, 32'd0);
        chk({tag, ".out_eol"},   32'(out_eol), 32'd0);
        chk({tag, ".out_eof"},   32'(out_eof), 32'd0);
        chk({tag, ".sof_err"},   32'(sof_err), 32'd0);
    endtask

    // One clock cycle: drive, check same-cycle strobes, clock, check registered outputs.
    task automatic step(input bit v, input bit s, input logic [31:0] d);
        bit ready, acc, e_wr, e_rd, done_next;
        int e_sel, e_addr, row, col;
        bit n_ov, n_eol, n_eof, n_err;
        int n_col, n_row, n_base;
        logic [31:0] n_data;
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        #1;
        ready = !m_done;
        acc   = v && ready;
        e_wr = 0; e_rd = 0; e_sel = 0; e_addr = 0; done_next = 0;
        n_ov = 0; n_eol = 0; n_eof = 0; n_err = 0;
        n_col = 0; n_row = 0; n_base = 0; n_data = '0;
        if (acc && s) begin
            e_wr     = 1;
            n_err    = m_active;
            m_active = 1;
            m_pos    = 1;
        end else if (acc && m_active) begin
            row    = m_pos / RWD;
            col    = m_pos % RWD;
            e_wr   = 1;
            e_sel  = row % BR;
            e_addr = col;
            if (row >= K - 1) begin
                e_rd   = 1;
                n_ov   = 1;
                n_col  = col;
                n_row  = row;
                n_base = (row - (K - 1)) % BR;
                n_data = d;
                n_eol  = (col == RWD - 1);
                n_eof  = (m_pos == TOTAL - 1);
            end
            m_pos++;
            if (m_pos == TOTAL) begin
                m_active  = 0;
                m_pos     = 0;
                done_next = 1;
            end
        end
        chk("in_ready", 32'(in_ready), 32'(ready));
        chk("wr_en", 32'(wr_en), 32'(e_wr));
        if (e_wr) begin
            chk("wr_sel",  32'(wr_sel), e_sel);
            chk("wr_addr", 32'(wr_addr), e_addr);
            chk("wr_data", wr_data, d);
        end
        chk("rd_en", 32'(rd_en), 32'(e_rd));
        if (e_rd) begin
            chk("rd_addr", 32'(rd_addr), e_addr);
        end
        m_done = done_next;
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(n_ov));
        chk("out_col",   32'(out_col), n_col);
        chk("out_row",   32'(out_row), n_row);
        chk("out_base",  32'(out_base_sel), n_base);
        chk("out_data",  out_cur_data, n_data);
        chk("out_eol",   32'(out_eol), 32'(n_eol));
        chk("out_eof",   32'(out_eof), 32'(n_eof));
        chk("sof_err",   32'(sof_err), 32'(n_err));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet_outputs("reset");
        rst_n = 1'b1;
        model_reset();

        // IDLE discards words that do not start a frame
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom);

        // two back-to-back full frames with index data, then the DONE cycle
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < TOTAL; i++) step(1'b1, (i == 0), 32'(i));
            step(1'b1, 1'b0, 32'hDEAD_BEEF);
        end

        // valid toggling every cycle through the frame
        step(1'b1, 1'b1, $urandom);
        for (int i = 1; i < TOTAL; i++) begin
            step(1'b0, 1'b0, $urandom);
            step(1'b1, 1'b0, $urandom);
        end
        step(1'b0, 1'b0, $urandom);
        step(1'b0, 1'b0, $urandom);

        // start-of-frame again at beat 10 restarts the frame
        for (int i = 0; i < 10; i++) step(1'b1, (i == 0), $urandom);
        step(1'b1, 1'b1, $urandom);
        for (int i = 1; i < TOTAL; i++) step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b0, $urandom);
        step(1'b0, 1'b0, $urandom);

        // asynchronous reset in the middle of beat 9
        for (int i = 0; i < 9; i++) step(1'b1, (i == 0), $urandom);
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = $urandom;
        #1;
        rst_n = 1'b0;
        #1;
        check_quiet_outputs("async_rst");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < TOTAL; i++) step(1'b1, (i == 0), 32'(i + 100));
        step(1'b1, 1'b0, $urandom);

        // random traffic with occasional frame starts
        for (int i = 0; i < 500; i++) begin
            bit v, s;
            v = ($urandom_range(0, 3) != 0);
            if (m_active) s = ($urandom_range(0, 59) == 0);
            else          s = ($urandom_range(0, 2) == 0);
            step(v, s, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
